// File: rtl/cpu_pkg.sv
// Shared simpleCPU2 definitions: opcode set, instruction-memory loader states, bus widths.
package cpu_pkg;

  localparam int unsigned IMEM_ADDR_W = 8;
  localparam int unsigned INSTR_W     = 16;

  typedef enum logic [3:0] {
    OP_LOAD      = 4'h0,
    OP_STORE     = 4'h1,
    OP_ADD       = 4'h2,
    OP_LOAD_CONS = 4'h3,
    OP_SUB       = 4'h4,
    OP_JMPZ      = 4'h5,
    OP_ABS       = 4'h6
  } t_opcode;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE,
    ST_RUN,
    ST_HALT
  } t_imem_state;

  function automatic logic op_illegal(input logic [3:0] op, input logic [3:0] max_op);
    return op > max_op;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: one synchronous write port, one asynchronous read port, contents not reset.
module imem_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction-memory loader/responder: downloads an image, screens opcodes, holds the CPU in reset
// until a clean image is present. Define IMEM_CHECKSUM_EN to build the running load checksum.
module instr_mem_loader
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W     = IMEM_ADDR_W,
  parameter int unsigned DATA_W     = INSTR_W,
  parameter int unsigned MAX_OPCODE = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic              I_rd,
  output logic [DATA_W-1:0] I_data,
  output logic              cpu_rst,
  output logic [ADDR_W:0]   load_count,
  output logic              err_bad_op,
  output logic [DATA_W-1:0] load_csum
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [3:0]        MAX_OP    = 4'(MAX_OPCODE);

  t_imem_state       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_load_count;
  logic              r_err_bad_op;
  logic              w_load_ready;
  logic              w_accept;
  logic              w_bad_word;
  logic [DATA_W-1:0] w_rd_data;

  // A restart cycle never accepts a word, so load_start also gates ready.
  assign w_load_ready = (r_state == ST_LOAD) && !load_start;
  assign w_accept     = load_valid && w_load_ready;
  assign w_bad_word   = op_illegal(load_data[DATA_W-1 -: 4], MAX_OP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (load_start) begin
      w_state_nxt = ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD: if (w_accept && (load_last || r_wr_ptr == LAST_ADDR)) w_state_nxt = ST_DONE;
        ST_DONE: w_state_nxt = r_err_bad_op ? ST_HALT : ST_RUN;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // The pointer parks on the last address after a full-depth image instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_load_count <= '0;
      r_err_bad_op <= 1'b0;
    end else if (load_start) begin
      r_wr_ptr     <= '0;
      r_load_count <= '0;
      r_err_bad_op <= 1'b0;
    end else if (w_accept) begin
      if (r_wr_ptr != LAST_ADDR) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_load_count <= r_load_count + (ADDR_W+1)'(1);
      if (w_bad_word) r_err_bad_op <= 1'b1;
    end
  end

`ifdef IMEM_CHECKSUM_EN
  logic [DATA_W-1:0] r_load_csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_load_csum <= '0;
    else if (load_start) r_load_csum <= '0;
    else if (w_accept)   r_load_csum <= r_load_csum + load_data;
  end

  assign load_csum = r_load_csum;
`else
  assign load_csum = '0;
`endif

  imem_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_accept),
    .i_waddr(r_wr_ptr),
    .i_wdata(load_data),
    .i_raddr(I_addr),
    .o_rdata(w_rd_data)
  );

  assign load_ready = w_load_ready;
  assign cpu_rst    = (r_state != ST_RUN);
  assign I_data     = ((r_state == ST_RUN) && I_rd) ? w_rd_data : '0;
  assign load_count = r_load_count;
  assign err_bad_op = r_err_bad_op;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: driver pushes model predictions, a negedge monitor checks them.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic        load_last = 1'b0;
  logic [7:0]  I_addr = '0;
  logic        I_rd = 1'b0;
  logic        load_ready;
  logic [15:0] I_data;
  logic        cpu_rst;
  logic [8:0]  load_count;
  logic        err_bad_op;
  logic [15:0] load_csum;

  always #5 clk = ~clk;

  instr_mem_loader #(
    .ADDR_W(8),
    .DATA_W(16),
    .MAX_OPCODE(6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_last (load_last),
    .load_ready(load_ready),
    .I_addr    (I_addr),
    .I_rd      (I_rd),
    .I_data    (I_data),
    .cpu_rst   (cpu_rst),
    .load_count(load_count),
    .err_bad_op(err_bad_op),
    .load_csum (load_csum)
  );

  typedef struct {
    logic        ready;
    logic        cpu_rst;
    logic [8:0]  count;
    logic        bad;
    logic [15:0] csum;
    logic [15:0] idata;
    bit          chk_idata;
    string       tag;
  } exp_t;

  exp_t  sbq[$];
  int    checks = 0;
  int    errors = 0;
  string cur_tag = "reset";

  // Reference model: the image as written so far plus a few status facts.
  logic [15:0] m_mem [256];
  bit          m_valid [256];
  bit          m_loading = 0;
  bit          m_complete = 0;
  int          m_age = 0;
  int          m_ptr = 0;
  int          m_count = 0;
  bit          m_bad = 0;
  logic [15:0] m_csum = '0;

  task automatic chk(input string tag, input string what, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %h expected %h at %0t", tag, what, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk(e.tag, "load_ready", 16'(load_ready), 16'(e.ready));
      chk(e.tag, "cpu_rst", 16'(cpu_rst), 16'(e.cpu_rst));
      chk(e.tag, "load_count", 16'(load_count), 16'(e.count));
      chk(e.tag, "err_bad_op", 16'(err_bad_op), 16'(e.bad));
      chk(e.tag, "load_csum", load_csum, e.csum);
      if (e.chk_idata) chk(e.tag, "I_data", I_data, e.idata);
    end
  end

  task automatic cycle(input bit st, input bit v, input logic [15:0] d, input bit last,
                       input logic [7:0] a, input bit rd);
    exp_t e;
    bit   run;
    load_start = st; load_valid = v; load_data = d; load_last = last; I_addr = a; I_rd = rd;
    // The CPU runs from the second cycle after a clean image completes.
    run = m_complete && (m_age >= 1) && !m_bad && !rst;
    e.ready   = m_loading && !st && !rst;
    e.cpu_rst = !run;
    e.count   = 9'(m_count);
    e.bad     = m_bad;
`ifdef IMEM_CHECKSUM_EN
    e.csum    = m_csum;
`else
    e.csum    = 16'h0;
`endif
    e.idata     = (run && rd) ? m_mem[a] : 16'h0;
    e.chk_idata = !(run && rd) || m_valid[a];
    e.tag       = cur_tag;
    sbq.push_back(e);
    @(posedge clk);
    if (rst) begin
      m_loading = 0; m_complete = 0; m_ptr = 0; m_count = 0; m_bad = 0; m_csum = '0;
    end else if (st) begin
      m_loading = 1; m_complete = 0; m_ptr = 0; m_count = 0; m_bad = 0; m_csum = '0;
    end else if (m_loading && v) begin
      m_mem[m_ptr] = d;
      m_valid[m_ptr] = 1;
      m_count++;
      if (d[15:12] > 4'd6) m_bad = 1;
      m_csum = m_csum + d;
      if (last || m_ptr == 255) begin
        m_loading = 0; m_complete = 1; m_age = 0;
      end else begin
        m_ptr++;
      end
    end else if (m_complete && m_age < 2) begin
      m_age++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 16'h0, 0, 8'h0, 0);
  endtask

  task automatic word(input logic [15:0] d, input bit last);
    cycle(0, 1, d, last, 8'h0, 0);
  endtask

  task automatic fetch(input logic [7:0] a);
    cycle(0, 0, 16'h0, 0, a, 1);
  endtask

  function automatic logic [15:0] rand_word(input int bad_pct);
    logic [3:0] op;
    op = ($urandom_range(0, 99) < bad_pct) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
    return {op, 12'($urandom)};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) m_valid[i] = 0;
    @(posedge clk); #1;
    idle(2);
    rst = 1'b0;
    cur_tag = "post_reset";
    idle(2);

    cur_tag = "t1_basic";
    cycle(1, 0, 16'h0, 0, 8'h0, 0);
    word(16'h3105, 0);
    word(16'h3203, 0);
    word(16'h2312, 1);
    fetch(8'd2);
    fetch(8'd2);
    fetch(8'd0);
    fetch(8'd1);
    cycle(0, 0, 16'h0, 0, 8'd2, 0);

    cur_tag = "t2_badop";
    cycle(1, 0, 16'h0, 0, 8'h0, 0);
    word(16'h7000, 0);
    word(16'h0100, 1);
    fetch(8'd0);
    fetch(8'd0);
    fetch(8'd1);
    cycle(1, 0, 16'h0, 0, 8'h0, 0);
    word(16'h1234, 0);
    word(16'h6fff, 1);
    idle(1);
    fetch(8'd0);
    fetch(8'd1);

    cur_tag = "t3_full";
    cycle(1, 0, 16'h0, 0, 8'h0, 0);
    for (int i = 0; i < 256; i++) word(rand_word(0), 0);
    word(16'h5555, 0);
    word(16'h4444, 1);
    fetch(8'd0);
    fetch(8'd255);
    for (int i = 0; i < 8; i++) fetch(8'($urandom));

    cur_tag = "t4_restart_in_run";
    cycle(1, 1, 16'h6abc, 0, 8'd0, 1);
    word(16'h0111, 0);
    word(16'h0222, 1);
    idle(1);
    fetch(8'd0);
    fetch(8'd1);

    cur_tag = "t5_restart_vs_accept";
    cycle(1, 0, 16'h0, 0, 8'h0, 0);
    word(16'h2001, 0);
    cycle(1, 1, 16'h2002, 1, 8'h0, 0);
    word(16'h2003, 1);
    idle(1);
    fetch(8'd0);

    cur_tag = "t5_random";
    for (int i = 0; i < 600; i++) begin
      bit         st, v, last, rd;
      logic [7:0] a;
      st   = ($urandom_range(0, 39) == 0);
      v    = ($urandom_range(0, 1) == 1);
      last = ($urandom_range(0, 7) == 0);
      rd   = ($urandom_range(0, 1) == 1);
      a    = (m_count > 0) ? 8'($urandom_range(0, m_count - 1)) : 8'($urandom);
      cycle(st, v, rand_word(10), last, a, rd);
    end

    cur_tag = "t6_csum";
    cycle(1, 0, 16'h0, 0, 8'h0, 0);
    word(16'hFFFF, 0);
    word(16'h0002, 1);
    idle(2);
    fetch(8'd1);

    for (int i = 0; i < 4 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
